// File: rtl/dram_block_responder.sv
// Block-organised DRAM model serving the instruction and data cache fill ports.
// Round-robin arbitration, one transaction at a time, fixed BUSY latency.
module dram_block_responder #(
   parameter int ADDR_W       = 32,
   parameter int WORD_W       = 32,
   parameter int BLOCK_WORDS  = 4,
   parameter int DEPTH_BLOCKS = 64,
   parameter int LATENCY      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dram_port1_request,
   input  logic [ADDR_W-1:0] dram_port1_address,
   output logic              dram_port1_acknowledge,
   output logic [WORD_W-1:0] dram_port1_read_data [BLOCK_WORDS],
   input  logic              dram_port2_request,
   input  logic [ADDR_W-1:0] dram_port2_address,
   input  logic              dram_port2_we,
   input  logic [WORD_W-1:0] dram_port2_write_data [BLOCK_WORDS],
   output logic              dram_port2_acknowledge,
   output logic [WORD_W-1:0] dram_port2_read_data [BLOCK_WORDS],
   output logic              dram_busy
);

   localparam int OFF_W = $clog2(BLOCK_WORDS * WORD_W / 8);
   localparam int IDX_W = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t             state_reg;
   logic               grant_reg;        // 0 = port 1, 1 = port 2
   logic               last_grant_reg;
   logic               we_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [WORD_W-1:0]  wdata_reg [BLOCK_WORDS];
   logic [WORD_W-1:0]  rd_word [BLOCK_WORDS];

   logic [IDX_W-1:0]   idx1;
   logic [IDX_W-1:0]   idx2;
   logic               pick;
   logic               finish;
   logic               unused_addr_bits;

   // Offset bits drop out and upper bits alias, since DEPTH_BLOCKS is a power of two.
   assign idx1 = dram_port1_address[OFF_W +: IDX_W];
   assign idx2 = dram_port2_address[OFF_W +: IDX_W];
   assign unused_addr_bits = ^{dram_port1_address, dram_port2_address};

   // Port 2 wins when alone, or on a tie when port 1 was served last.
   assign pick   = dram_port2_request & (~dram_port1_request | ~last_grant_reg);
   assign finish = (state_reg == BUSY) && (cnt_reg == '0);

   assign dram_busy = (state_reg != IDLE);

   genvar gi;
   generate
      for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_bank
         logic [WORD_W-1:0] bank [DEPTH_BLOCKS];

         always_ff @(posedge clk) begin
            if (finish && we_reg)
               bank[idx_reg] <= wdata_reg[gi];
         end

         assign rd_word[gi] = bank[idx_reg];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg              <= IDLE;
         grant_reg              <= 1'b0;
         last_grant_reg         <= 1'b0;
         we_reg                 <= 1'b0;
         idx_reg                <= '0;
         cnt_reg                <= '0;
         dram_port1_acknowledge <= 1'b0;
         dram_port2_acknowledge <= 1'b0;
         for (int w = 0; w < BLOCK_WORDS; w++) begin
            wdata_reg[w]            <= '0;
            dram_port1_read_data[w] <= '0;
            dram_port2_read_data[w] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (dram_port1_request || dram_port2_request) begin
                  grant_reg <= pick;
                  we_reg    <= pick & dram_port2_we;
                  idx_reg   <= pick ? idx2 : idx1;
                  cnt_reg   <= CNT_LOAD;
                  for (int w = 0; w < BLOCK_WORDS; w++)
                     wdata_reg[w] <= dram_port2_write_data[w];
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_reg == '0) begin
                  if (grant_reg) begin
                     dram_port2_acknowledge <= 1'b1;
                     for (int w = 0; w < BLOCK_WORDS; w++)
                        dram_port2_read_data[w] <= we_reg ? wdata_reg[w] : rd_word[w];
                  end else begin
                     dram_port1_acknowledge <= 1'b1;
                     for (int w = 0; w < BLOCK_WORDS; w++)
                        dram_port1_read_data[w] <= rd_word[w];
                  end
                  state_reg <= ACK;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ACK: begin
               dram_port1_acknowledge <= 1'b0;
               dram_port2_acknowledge <= 1'b0;
               last_grant_reg         <= grant_reg;
               state_reg              <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dram_block_responder.md
# dram_block_responder

Memory-side responder for the two cache-to-DRAM request ports: port 1 serves instruction-cache block fills (read only) and port 2 serves data-cache block fills and write-backs. It holds a block-organised backing store, arbitrates the two ports round-robin, and serves one transaction at a time with a fixed, parameterised latency. While it is occupied it drives `dram_busy`, which the top level ORs into the pipeline-wide cache-miss stall.

## Interface

- `ADDR_W`, default 32: byte-address width, equal to `DRAM_ADDRESS_SIZE`.
- `WORD_W`, default 32: word width, equal to `DRAM_WORD_SIZE`.
- `BLOCK_WORDS`, default 4: words per block, equal to `DRAM_BLOCK_SIZE`; must be a power of two.
- `DEPTH_BLOCKS`, default 64: number of blocks in the store; must be a power of two.
- `LATENCY`, default 4: number of BUSY cycles per transaction; must be ≥1.

- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low; 0 = reset.
- `dram_port1_request`, in, 1: instruction-side request, held until acknowledged.
- `dram_port1_address`, in, `ADDR_W`: instruction-side block byte address.
- `dram_port1_acknowledge`, out, 1: one-cycle completion pulse for port 1.
- `dram_port1_read_data[BLOCK_WORDS]`, out, `WORD_W` each: block returned on port 1.
- `dram_port2_request`, in, 1: data-side request, held until acknowledged.
- `dram_port2_address`, in, `ADDR_W`: data-side block byte address.
- `dram_port2_we`, in, 1: 1 = write block, 0 = read block.
- `dram_port2_write_data[BLOCK_WORDS]`, in, `WORD_W` each: block to be written.
- `dram_port2_acknowledge`, out, 1: one-cycle completion pulse for port 2.
- `dram_port2_read_data[BLOCK_WORDS]`, out, `WORD_W` each: block returned on port 2.
- `dram_busy`, out, 1: high whenever a transaction is in progress.

## Operation

- **Block index:** `address >> log2(BLOCK_WORDS*WORD_W/8)`, taken modulo `DEPTH_BLOCKS`. Offset bits are ignored, and addresses above the store alias (wrap-around).
- **States:** IDLE, BUSY, ACK.
- **IDLE:**
  - If no request is high, remain in IDLE.
  - If exactly one request is high, grant that port.
  - If both are high, grant the port not granted last. The `last_grant` pointer resets to port 1, so the first tie goes to port 2.
  - On a grant: latch the port number, the block index, `we` (forced to 0 for port 1) and the write data; load the counter with `LATENCY-1`; go to BUSY.
- **BUSY:** decrement the counter. When it reaches 0:
  - For a read, register the addressed block into the granted port's `read_data`.
  - For a write, write the latched data into the store and also register it into `dram_port2_read_data`.
  - Go to ACK.
- **ACK:** pulse the granted port's acknowledge for exactly one cycle, update `last_grant`, and return to IDLE.
- **Request capture:**
  - Inputs are sampled only in IDLE.
  - Address, data or request changes during BUSY or ACK are ignored.
  - A request dropped mid-transaction still completes and is still acknowledged.
  - A request still high in the IDLE cycle after an ACK is treated as a new request.
- **`dram_busy`:** equals `state != IDLE`.
- **`read_data` outputs:** hold their last value until the next acknowledge on the same port.
- **Reset:**
  - Asynchronously forces IDLE, both acknowledges to 0, `dram_busy` to 0, both `read_data` outputs to all-zero, and `last_grant` to port 1.
  - A transaction in flight is abandoned and never acknowledged.
  - The store contents are not cleared by reset.

## Timing

- A request sampled in IDLE at cycle t produces:
  - BUSY in cycles t+1 … t+`LATENCY`;
  - acknowledge and valid `read_data` in cycle t+`LATENCY`+1;
  - IDLE again in cycle t+`LATENCY`+2.
- The minimum spacing between two grants is `LATENCY`+2 cycles.
- A write is visible to any read granted after its ACK cycle.
- No combinational path exists from any input to any output; all outputs are registered or decoded from the state register.

## Test plan

- **Reset values:** hold `reset`=0 with both requests high → both acknowledges, `dram_busy` and all `read_data` stay 0. Release reset → first grant occurs in the next cycle.
- **Write then read, `LATENCY`=4:**
  - Port 2 write to 0x40 with data {1,2,3,4}, request first sampled at t=0 → `dram_busy`=1 during t1–t5, `dram_port2_acknowledge` high only at t5.
  - Then a port 1 read of 0x40 sampled at t6 → ack at t11 with `dram_port1_read_data`={1,2,3,4}.
- **Simultaneous requests:**
  - Both ports request from reset → port 2 acknowledged at t5, port 1 acknowledged at t11.
  - A second tie → port 1 is served first.
- **Wrap-around, `DEPTH_BLOCKS`=64 with 16-byte blocks:**
  - Write {A,B,C,D} to 0x400 → a read of 0x000 returns {A,B,C,D}.
  - A read of 0x40C returns the block at 0x400, because offset bits are ignored.
- **Reset mid-operation:**
  - Assert reset at t2 of a port 1 read → no acknowledge ever pulses and `dram_busy` drops immediately.
  - Previously written blocks still read back correctly after reset.
- **Address and request changes during BUSY:**
  - Change `dram_port1_address` at t2 → the data returned is from the originally latched address.
  - Drop the request at t2 → the acknowledge still pulses at t5.
